// File: rtl/gbprocessor_sequencer.sv
// gbprocessor_sequencer: streams a loaded opcode program into gbprocessor a programmable number of times.
// Optional GBSEQ_PAUSE_EN adds a pause input that stalls the stream without skipping opcodes.
module gbprocessor_sequencer #(
  parameter int DEPTH = 256,
  parameter int AW = 8,
  parameter int IW = 8
) (
  input  logic          clock,
  input  logic          reset,
`ifdef GBSEQ_PAUSE_EN
  input  logic          pause,
`endif
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          start,
  input  logic [AW:0]   length,
  input  logic [7:0]    repeats,
  output logic [IW-1:0] instruction,
  output logic          valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] pc_next;
  logic [AW:0] len, len_next;
  logic [7:0] pass_left, pass_next;
  logic [IW-1:0] rd;
  logic hold, last, wr;
`ifdef GBSEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  assign wr = load_en && state == IDLE;
  assign last = {1'b0, pc} == len - (AW+1)'(1);
  // Forward a same-edge write so start plus load to address 0 streams the new opcode.
  assign rd = (wr && load_addr == pc_next) ? load_data : mem[pc_next];
  assign valid = state == RUN && !hold;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_next = state;
    pc_next = pc;
    len_next = len;
    pass_next = pass_left;
    case (state)
      IDLE: if (start) begin
        state_next = |length ? RUN : DONE;
        pc_next = '0;
        len_next = length;
        pass_next = repeats;
      end
      RUN: if (!hold) begin
        pc_next = last ? '0 : pc + AW'(1);
        state_next = (last && ~|pass_left) ? DONE : RUN;
        pass_next = (last && |pass_left) ? pass_left - 8'd1 : pass_left;
      end
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (wr) mem[load_addr] <= load_data;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc <= '0;
      len <= '0;
      pass_left <= '0;
      instruction <= '0;
    end else begin
      state <= state_next;
      pc <= pc_next;
      len <= len_next;
      pass_left <= pass_next;
      if (state_next == RUN) instruction <= rd;
    end
  end
endmodule

// File: tb/tb_gbprocessor_sequencer.sv
// tb_gbprocessor_sequencer: random and directed program runs checked against an expected opcode stream.
module tb_gbprocessor_sequencer;
  logic clock = 0, reset = 0, pause = 0, load_en = 0, start = 0;
  logic [7:0] load_addr = 0, load_data = 0, repeats = 0;
  logic [8:0] length = 0;
  logic [7:0] instruction, pc;
  logic valid, busy, done;
  logic [7:0] ref_mem [256];
  int vectors = 0, miscompares = 0;

  gbprocessor_sequencer dut (
    .clock(clock), .reset(reset),
`ifdef GBSEQ_PAUSE_EN
    .pause(pause),
`endif
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .length(length), .repeats(repeats),
    .instruction(instruction), .valid(valid), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input logic [7:0] d);
    @(posedge clock); #1;
    load_en = 1; load_addr = 8'(a); load_data = d;
    ref_mem[a] = d;
    @(posedge clock); #1;
    load_en = 0;
  endtask

  // inj: stream index at which a write and a start are attempted; pat: index at which to pause 3 cycles;
  // pre: value written to address 0 in the same cycle as start
  task automatic run(input int n, input int r, input int inj, input int pat, input int pre);
    int idx = 0, cyc = 0, pz = 0, pa = pat;
    @(posedge clock); #1;
    start = 1; length = 9'(n); repeats = 8'(r);
    if (pre >= 0) begin
      load_en = 1; load_addr = 0; load_data = 8'(pre); ref_mem[0] = 8'(pre);
    end
    @(posedge clock); #1;
    start = 0; load_en = 0;
    @(negedge clock);
    while (!done && cyc < 3000) begin
      if (valid) begin
        check("pc", pc, idx % n);
        check("instr", instruction, ref_mem[idx % n]);
        idx++;
      end else if (pause) check("paused_pc", pc, idx % n);
      else check("gap", valid, 1);
      @(posedge clock); #1;
      load_en = 0; start = 0;
      if (pz > 0) begin
        pz--;
        pause = pz > 0;
      end else if (idx == pa) begin
        pause = 1; pz = 3; pa = -1;
      end
      if (idx == inj) begin
        load_en = 1; load_addr = 1; load_data = 8'hFF; start = 1;
      end
      @(negedge clock);
      cyc++;
    end
    load_en = 0; start = 0; pause = 0;
    check("done", done, 1);
    check("count", idx, n * (r + 1));
    check("busy_done", busy, 0);
    check("valid_done", valid, 0);
    @(negedge clock);
    check("done_pulse", done, 0);
  endtask

  initial begin
    int seen = 0, n, r;
    repeat (3) @(negedge clock);
    reset = 1;
    @(negedge clock);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc", pc, 0);
    check("rst_instr", instruction, 0);
    repeat (20) begin
      @(negedge clock);
      seen += int'(valid | busy | done);
    end
    check("idle_quiet", seen, 0);

    load(0, 8'h3C); load(1, 8'h04); load(2, 8'h80); load(3, 8'hAF);
    run(4, 0, -1, -1, -1);
    run(4, 2, -1, -1, -1);
    run(4, 1, 2, -1, -1);
    run(4, 0, -1, -1, -1);

    @(posedge clock); #1;
    start = 1; length = 4; repeats = 0;
    @(posedge clock); #1;
    start = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (valid && pc == 2) break;
    end
    check("mid_reach", pc, 2);
    reset = 0;
    #1;
    check("mid_valid", valid, 0);
    check("mid_busy", busy, 0);
    check("mid_pc", pc, 0);
    check("mid_instr", instruction, 0);
    @(posedge clock); #1;
    reset = 1;
    run(4, 0, -1, -1, -1);
`ifdef GBSEQ_PAUSE_EN
    run(4, 1, -1, 1, -1);
`endif
    run(4, 0, -1, -1, 8'h5A);
    run(0, 3, -1, -1, -1);

    for (int i = 0; i < 256; i++) load(i, 8'(i));
    run(256, 0, -1, -1, -1);

    repeat (8) begin
      n = $urandom_range(1, 12);
      r = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) load(i, 8'($urandom));
      run(n, r, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gbprocessor_sequencer.md
Name: gbprocessor_sequencer

Overview:
- Instruction sequencer directly upstream of gbprocessor.
- Holds a small program of 8-bit opcodes, loaded through a write port while idle.
- On start, streams the program into gbprocessor's instruction/valid inputs, one opcode per cycle, repeating the program a programmable number of times.
- Replaces free-running testbench stimulus with a deterministic, replayable instruction stream.

Parameters:
- DEPTH, 256, number of program memory entries.
- AW, 8, address width; DEPTH equals 2**AW.
- IW, 8, instruction width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  write load_data into program memory at load_addr; honoured only in IDLE.
- load_addr  in  AW  program memory write address.
- load_data  in  IW  opcode to write.
- start  in  1  one-cycle pulse to begin streaming; honoured only in IDLE.
- length  in  AW+1  number of opcodes per pass (0..DEPTH); sampled on start.
- repeats  in  8  extra passes after the first; sampled on start; total passes = repeats+1.
- instruction  out  IW  opcode to gbprocessor.
- valid  out  1  instruction is valid this cycle.
- pc  out  AW  address of the opcode currently presented.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when streaming completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - instruction=0, valid=0, pc=0, busy=0, done=0; state=IDLE.
  - Internal length/pass counters cleared.
  - Program memory is not cleared.
- Memory:
  - Write is synchronous: load_en=1 in IDLE writes mem[load_addr]=load_data at the clock edge.
  - load_en outside IDLE is ignored; memory unchanged.
  - Read is asynchronous from pc_next; instruction is registered.
- States:
  - IDLE:
    - start=1 with length>0: latch len=length, pass_left=repeats; go to RUN.
    - start=1 with length=0: go to DONE; no valid is ever asserted.
  - RUN:
    - Each cycle presents valid=1, instruction=mem[pc], busy=1.
    - First valid appears in the cycle after start is sampled, with pc=0.
    - When pc=len-1 and pass_left>0: pc wraps to 0 next cycle; pass_left decrements.
    - When pc=len-1 and pass_left=0: go to DONE.
  - DONE:
    - Single cycle: done=1, valid=0, busy=0; then IDLE.
- Valid train: valid is high for exactly len*(repeats+1) consecutive cycles, with no gaps (unless the optional feature is enabled).
- Counter widths:
  - pc is AW bits.
  - length=DEPTH (MSB set) is legal; pc wraps from DEPTH-1 to 0 naturally.
  - pass_left is 8 bits; repeats=255 gives 256 passes.
- Simultaneous events:
  - start and load_en in the same IDLE cycle: the write completes, and streaming reads the new value if the address is 0.
  - start during RUN or DONE is ignored.
- Outputs while not in RUN:
  - valid=0.
  - instruction holds its last value.
- Reset mid-RUN: outputs go to reset values immediately; the next start restarts at pc=0.

Optional Feature:
- Macro: GBSEQ_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - While pause=1 in RUN: valid=0; pc, pass_left and instruction freeze.
  - On pause deassertion, streaming resumes with the same pc. No opcode is skipped or duplicated.
  - pause has no effect in IDLE/DONE.
  - done is delayed by the number of paused cycles.
- Undefined: no pause port; streaming is always back-to-back.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release -> valid=0, busy=0, done=0, pc=0. No valid over 20 idle cycles.
- Single pass:
  - Stimulus: load mem[0..3]=0x3C,0x04,0x80,0xAF; start with length=4, repeats=0.
  - Required: valid high for exactly 4 cycles beginning the cycle after start; instruction=0x3C,0x04,0x80,0xAF; pc=0,1,2,3; done pulses in the next cycle; busy low after.
- Repeat wrap:
  - Stimulus: same program, length=4, repeats=2.
  - Required: 12 consecutive valid cycles; pc sequence 0..3 three times; a single done pulse.
- Boundaries:
  - length=0: done in the cycle after start, zero valid cycles.
  - length=256 with all locations loaded (mem[i]=i): 256 valid cycles; instruction=pc each cycle; pc wraps 255->0 only at end.
- Ignored requests during RUN:
  - Stimulus: load_en to addr 1 with data 0xFF, and a second start, both mid-stream.
  - Required: streamed opcodes are unchanged, a single done pulse, and mem[1] still holds its old value on the next run.
- Reset mid-run, plus pause when GBSEQ_PAUSE_EN is defined:
  - Reset asserted at pc=2 -> outputs cleared asynchronously; the next run starts at pc=0.
  - pause=1 for 3 cycles at pc=1 -> valid=0 for those cycles; the next valid shows pc=1; total valid count unchanged.
